// File: rtl/udp_frame_rx.sv
// udp_frame_rx: byte-wide Ethernet/IPv4/UDP receiver. It filters on MAC, IP and
// port, streams the UDP payload, and gives a good/bad verdict once per frame
// using an internal CRC-32 and a frame length check.
module udp_frame_rx #(
   parameter logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_01,
   parameter logic [31:0] LOCAL_IP    = 32'hC0A8_0164,
   parameter logic [15:0] LOCAL_PORT  = 16'd5000,
   parameter int          MAX_PAYLOAD = 1472
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  payload_data,
   output logic        payload_valid,
   output logic        payload_last,
   output logic        frame_good,
   output logic        frame_bad,
   output logic [15:0] drop_count
);

   typedef enum logic [3:0] {
      IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, PAD, DROP, CHECK
   } state_t;

   localparam logic [16:0] MAX_LEN     = 17'(8 + MAX_PAYLOAD);
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

   state_t      state;
   logic [4:0]  hdr_idx;
   logic        loc_ok, bc_ok;
   logic [7:0]  hi_byte;
   logic [15:0] udp_len;
   logic [10:0] pay_rem;
   logic        pay_done, reject, suppress, sync_wait;
   logic [10:0] byte_cnt;
   logic [31:0] crc;

   logic [7:0]  exp_mac, exp_ip;
   logic [15:0] hdr_word;
   logic        hdr_bad, counting, frame_ok;
   logic [31:0] crc_nxt;

   // One reflected CRC-32 step over a whole byte, LSB first
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // Header field expectations and the per-byte reject decision
   always_comb begin
      exp_mac = 8'h00;
      case (hdr_idx)
         5'd0: exp_mac = LOCAL_MAC[47:40];
         5'd1: exp_mac = LOCAL_MAC[39:32];
         5'd2: exp_mac = LOCAL_MAC[31:24];
         5'd3: exp_mac = LOCAL_MAC[23:16];
         5'd4: exp_mac = LOCAL_MAC[15:8];
         5'd5: exp_mac = LOCAL_MAC[7:0];
         default: ;
      endcase
      exp_ip = 8'h00;
      case (hdr_idx)
         5'd16: exp_ip = LOCAL_IP[31:24];
         5'd17: exp_ip = LOCAL_IP[23:16];
         5'd18: exp_ip = LOCAL_IP[15:8];
         5'd19: exp_ip = LOCAL_IP[7:0];
         default: ;
      endcase
      hdr_word = {hi_byte, rx_data};
      hdr_bad  = 1'b0;
      case (state)
         ETH_HDR:
            if (hdr_idx < 5'd6)
               hdr_bad = !(loc_ok && rx_data == exp_mac) && !(bc_ok && rx_data == 8'hFF);
            else if (hdr_idx == 5'd12)
               hdr_bad = (rx_data != 8'h08);
            else if (hdr_idx == 5'd13)
               hdr_bad = (rx_data != 8'h00);
         IP_HDR:
            if (hdr_idx == 5'd0)
               hdr_bad = (rx_data != 8'h45);
            else if (hdr_idx == 5'd9)
               hdr_bad = (rx_data != 8'h11);
            else if (hdr_idx >= 5'd16)
               hdr_bad = (rx_data != exp_ip);
         UDP_HDR:
            if (hdr_idx == 5'd3)
               hdr_bad = (hdr_word != LOCAL_PORT);
            else if (hdr_idx == 5'd5)
               hdr_bad = (hdr_word < 16'd8) || ({1'b0, hdr_word} > MAX_LEN);
         default: ;
      endcase
      counting = state inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, PAD, DROP};
      crc_nxt  = crc_byte(crc, rx_data);
      frame_ok = !reject && pay_done && (crc == CRC_RESIDUE) &&
                 (byte_cnt >= 11'd64) && (byte_cnt <= 11'd1518);
   end

   // Receive FSM with registered payload stream and verdict pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         hdr_idx       <= '0;
         loc_ok        <= 1'b0;
         bc_ok         <= 1'b0;
         hi_byte       <= '0;
         udp_len       <= '0;
         pay_rem       <= '0;
         pay_done      <= 1'b0;
         reject        <= 1'b0;
         suppress      <= 1'b0;
         sync_wait     <= 1'b1;   // a frame may be in flight when reset drops
         byte_cnt      <= '0;
         crc           <= 32'hFFFFFFFF;
         payload_data  <= '0;
         payload_valid <= 1'b0;
         payload_last  <= 1'b0;
         frame_good    <= 1'b0;
         frame_bad     <= 1'b0;
         drop_count    <= '0;
      end else begin
         payload_valid <= 1'b0;
         payload_last  <= 1'b0;
         frame_good    <= 1'b0;
         frame_bad     <= 1'b0;
         if (!rx_valid) sync_wait <= 1'b0;
         if (rx_valid && counting) begin
            crc <= crc_nxt;
            if (byte_cnt != '1) byte_cnt <= byte_cnt + 11'd1;
         end
         case (state)
            IDLE: begin
               reject   <= 1'b0;
               pay_done <= 1'b0;
               suppress <= 1'b0;
               crc      <= 32'hFFFFFFFF;
               byte_cnt <= '0;
               if (rx_valid) begin
                  if (sync_wait) begin
                     // tail of a frame cut by reset: swallow it silently
                     state    <= DROP;
                     suppress <= 1'b1;
                  end else if (rx_data == 8'h55) begin
                     state <= PREAMBLE;
                  end else begin
                     state  <= DROP;
                     reject <= 1'b1;
                  end
               end
            end
            PREAMBLE: begin
               if (!rx_valid) state <= CHECK;
               else if (rx_data == 8'hD5) begin
                  state   <= ETH_HDR;
                  hdr_idx <= '0;
                  loc_ok  <= 1'b1;
                  bc_ok   <= 1'b1;
               end else if (rx_data != 8'h55) begin
                  state  <= DROP;
                  reject <= 1'b1;
               end
            end
            ETH_HDR, IP_HDR, UDP_HDR: begin
               if (!rx_valid) state <= CHECK;
               else if (hdr_bad) begin
                  state  <= DROP;
                  reject <= 1'b1;
               end else begin
                  hdr_idx <= hdr_idx + 5'd1;
                  hi_byte <= rx_data;
                  if (state == ETH_HDR && hdr_idx < 5'd6) begin
                     loc_ok <= loc_ok && (rx_data == exp_mac);
                     bc_ok  <= bc_ok && (rx_data == 8'hFF);
                  end
                  if (state == UDP_HDR && hdr_idx == 5'd5) udp_len <= hdr_word;
                  if (state == ETH_HDR && hdr_idx == 5'd13) begin
                     state   <= IP_HDR;
                     hdr_idx <= '0;
                  end
                  if (state == IP_HDR && hdr_idx == 5'd19) begin
                     state   <= UDP_HDR;
                     hdr_idx <= '0;
                  end
                  if (state == UDP_HDR && hdr_idx == 5'd7) begin
                     if (udp_len == 16'd8) begin
                        state    <= PAD;
                        pay_done <= 1'b1;
                     end else begin
                        state   <= PAYLOAD;
                        pay_rem <= 11'(udp_len - 16'd8);
                     end
                  end
               end
            end
            PAYLOAD: begin
               if (!rx_valid) state <= CHECK;
               else begin
                  payload_data  <= rx_data;
                  payload_valid <= 1'b1;
                  payload_last  <= (pay_rem == 11'd1);
                  pay_rem       <= pay_rem - 11'd1;
                  if (pay_rem == 11'd1) begin
                     state    <= PAD;
                     pay_done <= 1'b1;
                  end
               end
            end
            PAD:  if (!rx_valid) state <= CHECK;
            DROP: if (!rx_valid) state <= suppress ? IDLE : CHECK;
            CHECK: begin
               state <= IDLE;
               if (frame_ok) frame_good <= 1'b1;
               else begin
                  frame_bad <= 1'b1;
                  if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_frame_rx.sv
// tb_udp_frame_rx: scoreboard bench. Frames are built as byte lists, a model
// parses the bytes actually sent and queues the expected payload stream and
// verdict; a monitor pops and compares whenever the DUT presents output.
module tb_udp_frame_rx;

   localparam logic [47:0] MAC  = 48'h02_00_00_00_00_01;
   localparam logic [31:0] IP   = 32'hC0A8_0164;
   localparam logic [15:0] PORT = 16'd5000;
   localparam int          MAXP = 1472;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [7:0]  payload_data;
   logic        payload_valid, payload_last, frame_good, frame_bad;
   logic [15:0] drop_count;

   udp_frame_rx #(.LOCAL_MAC(MAC), .LOCAL_IP(IP), .LOCAL_PORT(PORT), .MAX_PAYLOAD(MAXP)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .payload_data(payload_data), .payload_valid(payload_valid), .payload_last(payload_last),
      .frame_good(frame_good), .frame_bad(frame_bad), .drop_count(drop_count)
   );

   always #4 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [8:0]  exp_pay[$];   // {last, data}
   logic        exp_res[$];   // 1 = good
   int          exp_drops = 0;
   logic [7:0]  frm[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Textbook CRC-32 (Ethernet FCS value, final inversion applied)
   function automatic logic [31:0] crc32(input logic [7:0] q[$]);
      logic [31:0] c = 32'hFFFFFFFF;
      foreach (q[i]) begin
         c ^= {24'h0, q[i]};
         repeat (8) c = (c >> 1) ^ (32'hEDB88320 & {32{c[0]}});
      end
      return ~c;
   endfunction

   task automatic build(input logic [47:0] mac, input logic [15:0] et, input logic [7:0] ver,
                        input logic [7:0] proto, input logic [31:0] ip, input logic [15:0] port,
                        input logic [15:0] len, input int plen, input int min_len);
      logic [15:0] tot = len + 16'd20;
      frm = {};
      for (int i = 5; i >= 0; i--) frm.push_back(mac[8*i +: 8]);
      frm = {frm, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, et[15:8], et[7:0]};
      frm = {frm, ver, 8'h00, tot[15:8], tot[7:0], 8'h12, 8'h34, 8'h40, 8'h00, 8'h40, proto,
             8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h0A, ip[31:24], ip[23:16], ip[15:8], ip[7:0]};
      frm = {frm, 8'h13, 8'h88, port[15:8], port[7:0], len[15:8], len[7:0], 8'h00, 8'h00};
      for (int i = 0; i < plen; i++) frm.push_back(8'($urandom));
      while (frm.size() < min_len) frm.push_back(8'h00);
   endtask

   task automatic add_fcs();
      logic [31:0] c = crc32(frm);
      frm = {frm, c[7:0], c[15:8], c[23:16], c[31:24]};
   endtask

   // Reference model: judge the bytes that will actually be sent
   task automatic expect_frame();
      int          n = frm.size();
      logic        hdr_ok = 1'b0, complete = 1'b0, crc_ok = 1'b0;
      int          plen = 0;
      logic [47:0] mac;
      logic [31:0] ip;
      logic [15:0] port, len;
      logic [7:0]  body[$];
      if (n >= 42) begin
         mac  = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
         ip   = {frm[30], frm[31], frm[32], frm[33]};
         port = {frm[36], frm[37]};
         len  = {frm[38], frm[39]};
         hdr_ok = (mac == MAC || mac == 48'hFFFF_FFFF_FFFF) && {frm[12], frm[13]} == 16'h0800 &&
                  frm[14] == 8'h45 && frm[23] == 8'h11 && ip == IP && port == PORT &&
                  len >= 16'd8 && int'(len) <= 8 + MAXP;
      end
      if (hdr_ok) begin
         plen = int'(len) - 8;
         for (int i = 0; i < plen && 42 + i < n; i++)
            exp_pay.push_back({(i == plen - 1), frm[42+i]});
         complete = (n - 42) >= plen;
      end
      if (n >= 4) begin
         body   = frm[0:n-5];
         crc_ok = crc32(body) == {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
      end
      exp_res.push_back(hdr_ok && complete && crc_ok && n >= 64 && n <= 1518);
   endtask

   task automatic drive(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic send_frame();
      repeat (7) drive(8'h55);
      drive(8'hD5);
      foreach (frm[i]) drive(frm[i]);
      idle(6);
   endtask

   task automatic std_frame(input logic [15:0] len, input int plen, input int min_len);
      build(MAC, 16'h0800, 8'h45, 8'h11, IP, PORT, len, plen, min_len);
   endtask

   // Monitor: compare whatever the DUT presents against the scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (payload_valid) begin
            if (exp_pay.size() == 0) chk("unexpected_payload", {payload_last, payload_data}, 9'h1FF);
            else chk("payload", {23'h0, payload_last, payload_data}, {23'h0, exp_pay.pop_front()});
         end
         if (frame_good || frame_bad) begin
            chk("pulse_exclusive", {31'h0, frame_good & frame_bad}, 32'h0);
            if (exp_res.size() == 0) chk("unexpected_verdict", {30'h0, frame_good, frame_bad}, 32'h0);
            else begin
               logic e;
               e = exp_res.pop_front();
               chk("verdict_good", {31'h0, frame_good}, {31'h0, e});
               if (!e && exp_drops != 65535) exp_drops++;
               chk("drop_count", {16'h0, drop_count}, 32'(exp_drops));
            end
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_payload_valid", {31'h0, payload_valid}, 32'h0);
      chk("rst_payload_last", {31'h0, payload_last}, 32'h0);
      chk("rst_frame_good", {31'h0, frame_good}, 32'h0);
      chk("rst_frame_bad", {31'h0, frame_bad}, 32'h0);
      chk("rst_drop_count", {16'h0, drop_count}, 32'h0);
      rst = 1'b0;
      idle(3);

      // Directed: good L=12 DEADBEEF, then same with a flipped payload bit
      std_frame(16'd12, 4, 60);
      frm[42] = 8'hDE; frm[43] = 8'hAD; frm[44] = 8'hBE; frm[45] = 8'hEF;
      add_fcs(); expect_frame(); send_frame();
      frm[44] ^= 8'h01;
      expect_frame(); send_frame();
      // Wrong port, broadcast L=8, truncation after 2 of 4 payload bytes
      build(MAC, 16'h0800, 8'h45, 8'h11, IP, 16'd5001, 16'd12, 4, 60);
      add_fcs(); expect_frame(); send_frame();
      build(48'hFFFF_FFFF_FFFF, 16'h0800, 8'h45, 8'h11, IP, PORT, 16'd8, 0, 60);
      add_fcs(); expect_frame(); send_frame();
      std_frame(16'd12, 4, 60); add_fcs();
      frm = frm[0:43];
      expect_frame(); send_frame();
      // Length boundaries: 64, 63, 1518 (max payload), 1519, oversize L
      std_frame(16'd8, 0, 60);    add_fcs(); expect_frame(); send_frame();
      std_frame(16'd8, 0, 59);    add_fcs(); expect_frame(); send_frame();
      std_frame(16'(8 + MAXP), MAXP, 0); add_fcs(); expect_frame(); send_frame();
      std_frame(16'd8, 0, 1515);  add_fcs(); expect_frame(); send_frame();
      std_frame(16'(9 + MAXP), 4, 60); add_fcs(); expect_frame(); send_frame();

      // Reset during PAYLOAD: two bytes already out, no verdict for this frame
      std_frame(16'd12, 4, 60); add_fcs();
      exp_pay.push_back({1'b0, frm[42]});
      exp_pay.push_back({1'b0, frm[43]});
      repeat (7) drive(8'h55);
      drive(8'hD5);
      for (int i = 0; i < 44; i++) drive(frm[i]);
      @(negedge clk);
      #2 rst = 1'b1;
      rx_data = frm[44];
      exp_drops = 0;
      #1;
      chk("midrst_payload_valid", {31'h0, payload_valid}, 32'h0);
      chk("midrst_frame_pulses", {30'h0, frame_good, frame_bad}, 32'h0);
      chk("midrst_drop_count", {16'h0, drop_count}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 45; i < frm.size(); i++) drive(frm[i]);
      idle(6);
      std_frame(16'd12, 4, 60); add_fcs(); expect_frame(); send_frame();

      // Randomized frames with assorted header faults, bit flips, truncation
      for (int k = 0; k < 30; k++) begin
         int kind = $urandom_range(0, 9);
         int plen = $urandom_range(0, 40);
         logic [47:0] mac = ($urandom_range(0, 3) == 0) ? 48'hFFFF_FFFF_FFFF : MAC;
         logic [15:0] et = 16'h0800, port = PORT, len = 16'(plen + 8);
         logic [7:0]  ver = 8'h45, proto = 8'h11;
         logic [31:0] ip = IP;
         case (kind)
            1: mac   = 48'h02_00_00_00_00_02;
            2: et    = 16'h86DD;
            3: ver   = 8'h46;
            4: proto = 8'h06;
            5: ip    = IP ^ 32'h1;
            6: port  = 16'd5001;
            7: len   = ($urandom_range(0, 1) != 0) ? 16'd7 : 16'(9 + MAXP);
            default: ;
         endcase
         build(mac, et, ver, proto, ip, port, len, plen, 60);
         add_fcs();
         if (kind == 8) begin
            int bi = $urandom_range(0, frm.size() * 8 - 1);
            frm[bi/8] ^= 8'(1 << (bi % 8));
         end
         if (kind == 9) begin
            int tl = $urandom_range(0, frm.size() - 1);
            if (tl == 0) frm = {};
            else frm = frm[0:tl-1];
         end
         expect_frame();
         send_frame();
      end

      for (int i = 0; i < 200 && (exp_pay.size() != 0 || exp_res.size() != 0); i++) @(negedge clk);
      chk("payload_queue_drained", 32'(exp_pay.size()), 32'h0);
      chk("verdict_queue_drained", 32'(exp_res.size()), 32'h0);
      chk("final_drop_count", {16'h0, drop_count}, 32'(exp_drops));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
